// File: rtl/seq_div.sv
// Sequential restoring radix-2 unsigned divider: one quotient bit per clock,
// MSB first, with a divide-by-zero fast path that completes after one cycle.
module seq_div #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [M-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] q,
  output logic [M-1:0] r,
  output logic         dbz
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  dq;      // dividend bits shift out the top, quotient bits shift in the bottom
  logic [M-1:0]  rem;
  logic [M-1:0]  dvs;

  logic [M:0]    trial;
  logic          ge;
  logic [M-1:0]  rem_nxt;
  logic [N-1:0]  dq_nxt;

  // One restoring step; the remainder stays below dvs, so M bits suffice after subtraction
  always_comb begin
    trial   = {rem, dq[N-1]};
    ge      = (trial >= {1'b0, dvs});
    rem_nxt = ge ? (trial[M-1:0] - dvs) : trial[M-1:0];
    dq_nxt  = {dq[N-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      dq    <= '0;
      rem   <= '0;
      dvs   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      q     <= '0;
      r     <= '0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            dq    <= a;
            dvs   <= b;
            rem   <= '0;
            dbz   <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
            // A zero divisor spends a single RUN cycle, then reports the fixed result
            cnt   <= (b == '0) ? CW'(1) : CW'(N);
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          dq  <= dq_nxt;
          rem <= rem_nxt;
          if (cnt == CW'(1)) begin
            state <= DONE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (dvs == '0) begin
              q   <= '1;
              r   <= dq[M-1:0];
              dbz <= 1'b1;
            end else begin
              q   <= dq_nxt;
              r   <= rem_nxt;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 Parameter N, default 8: dividend and quotient width in bits, legal range 2..32.
REQ-002 Parameter M, default 4: divisor and remainder width in bits, legal range 1..N.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  request a division; sampled on each rising edge.
REQ-006 a  input  N  unsigned dividend; captured on the accepted start edge.
REQ-007 b  input  M  unsigned divisor; captured on the accepted start edge.
REQ-008 busy  output  1  high while an accepted division is in progress.
REQ-009 done  output  1  one-cycle pulse; q, r and dbz are valid in this cycle.
REQ-010 q  output  N  quotient of the last completed division.
REQ-011 r  output  M  remainder of the last completed division.
REQ-012 dbz  output  1  set when the last completed division had b==0.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE. All outputs SHALL be registered.
REQ-014 start SHALL be accepted only in IDLE or DONE. An accepted start at edge k SHALL capture a and b and clear dbz.
REQ-015 An accepted start with b!=0 SHALL enter RUN with the iteration counter set to N, and busy SHALL be 1 from edge k.
REQ-016 Each RUN edge SHALL perform one restoring radix-2 step, MSB of the dividend first, and decrement the counter.
    - Shift the partial remainder left (M+1 bits wide) and shift in the next dividend bit.
    - Subtract b if the result is >= b.
    - Shift the compare result into the quotient.
REQ-017 After the N-th RUN edge (edge k+N), the FSM SHALL enter DONE with done=1, busy=0 and the final q and r.
    - Start-to-done latency SHALL be exactly N cycles.
REQ-018 An accepted start with b==0 SHALL go directly to DONE at edge k+1, with latency 1.
    - q SHALL be all ones.
    - r SHALL be a[M-1:0].
    - dbz SHALL be 1.
REQ-019 DONE SHALL last one cycle. Without start the FSM SHALL then return to IDLE, and done SHALL drop to 0.
REQ-020 start asserted in DONE SHALL be accepted, giving back-to-back operation with no IDLE cycle.
REQ-021 start asserted while busy=1 SHALL be ignored. It SHALL NOT alter the operation in flight, its operands or its latency.
REQ-022 q, r and dbz SHALL hold their last completed values through IDLE and RUN until the next DONE.
    - Internal working registers SHALL NOT be visible on q or r before DONE.
REQ-023 Results SHALL satisfy a == q*b + r with r < b for every b!=0 and every a in 0..2^N-1.
REQ-024 Changes on a or b after the accepted start edge SHALL have no effect on the result.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE and clear the counter and working registers.
    - Outputs SHALL become busy=0, done=0, q=0, r=0, dbz=0.
REQ-026 rst SHALL take priority over start at the same edge. A start asserted together with rst SHALL be ignored.
REQ-027 rst asserted during RUN SHALL abort the operation, and no done pulse SHALL follow.

Verification (N=8, M=4)
REQ-028 Basic division: start, a=200, b=7.
    - busy=1 for 8 cycles.
    - done pulse at edge k+8 with q=28, r=4, dbz=0.
    - a changed to 0 during RUN does not alter the result.
REQ-029 Corner operands:
    - a=255, b=1 -> q=255, r=0.
    - a=3, b=15 -> q=0, r=3.
    - a=0, b=9 -> q=0, r=0.
    - All with latency 8.
REQ-030 Divide by zero: a=0x5F, b=0 -> done at edge k+1 with q=0xFF, r=0xF, dbz=1. The next valid division clears dbz.
REQ-031 Start handling:
    - start pulses during RUN are ignored, and the first result still arrives at k+8.
    - start held high through DONE launches a second division immediately, with done again 8 cycles later.
REQ-032 Reset mid-operation: rst at edge k+3 of a division gives busy=0, done=0, q=r=0, and no done pulse for 10 cycles. A fresh 100/3 then gives q=33, r=1.
REQ-033 Exhaustive random check: all 4096 (a,b) pairs against the reference model a/b, a%b. Every pair satisfies REQ-023 and REQ-018.
